// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: march-style built-in self-test sequencer for a DPRAM port.
// Runs write-P / read-P / write-~P / read-~P over every address, where
// P(a) = SEED ^ a, and reports pass, first failing address and a saturating
// mismatch count. Every output, including the RAM strobes, is a register.
// Optional build macro: BIST_STOP_ON_FAIL_EN -- abort the march on the first
// mismatch, discard in-flight reads and finish immediately.
module ram_bist_ctrl #(
    parameter int                    Data_Width   = 8,
    parameter int                    RAM_Depth    = 16,
    parameter int                    READ_LATENCY = 1,
    parameter logic [Data_Width-1:0] SEED         = Data_Width'(8'hA5)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic [$clog2(RAM_Depth)-1:0]    fail_addr,
    output logic [$clog2(2*RAM_Depth):0]    fail_count,
    output logic                            ram_cs,
    output logic                            ram_oe,
    output logic                            ram_wr_en,
    output logic [$clog2(RAM_Depth)-1:0]    ram_addr,
    output logic [Data_Width-1:0]           ram_data_in,
    input  logic [Data_Width-1:0]           ram_data_out
);

    localparam int AW = $clog2(RAM_Depth);
    localparam int CW = $clog2(2*RAM_Depth) + 1;

    localparam logic [AW-1:0] LAST_ADDR  = AW'(RAM_Depth - 1);
    localparam logic [2:0]    LAST_DRAIN = 3'(READ_LATENCY - 1);
    localparam logic [CW-1:0] COUNT_MAX  = '1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_W0   = 3'd1;
    localparam logic [2:0] ST_R0   = 3'd2;
    localparam logic [2:0] ST_D0   = 3'd3;
    localparam logic [2:0] ST_W1   = 3'd4;
    localparam logic [2:0] ST_R1   = 3'd5;
    localparam logic [2:0] ST_D1   = 3'd6;
    localparam logic [2:0] ST_FIN  = 3'd7;

    // Test pattern for one address: seed XOR zero-extended address.
    function automatic logic [Data_Width-1:0] pat_word(input logic [AW-1:0] a);
        return SEED ^ Data_Width'(a);
    endfunction

    // Sequencer state; r_addr doubles as the address counter and ram_addr.
    logic [2:0]            r_state;
    logic [AW-1:0]         r_addr;
    logic [2:0]            r_drain;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;
    logic [AW-1:0]         r_fail_addr;
    logic [CW-1:0]         r_fail_count;
    logic                  r_ram_cs;
    logic                  r_ram_oe;
    logic                  r_ram_wr_en;
    logic [Data_Width-1:0] r_ram_data_in;

    // Expected value of the read being issued this cycle (pipeline head).
    logic                  r_rd_valid;
    logic [Data_Width-1:0] r_rd_exp;

    // Compare pipeline: stage READ_LATENCY-1 lines up with ram_data_out.
    logic                  r_pipe_valid [READ_LATENCY];
    logic [AW-1:0]         r_pipe_addr  [READ_LATENCY];
    logic [Data_Width-1:0] r_pipe_exp   [READ_LATENCY];

    logic                  w_accept;
    logic                  w_mismatch;
    logic                  w_flush;
    logic [2:0]            w_state_next;
    logic [AW-1:0]         w_addr_next;
    logic [2:0]            w_drain_next;
    logic [CW-1:0]         w_fail_count_next;
    logic [AW-1:0]         w_fail_addr_next;
    logic                  w_pass_next;
    logic                  w_busy_next;
    logic                  w_done_next;
    logic                  w_cs_next;
    logic                  w_oe_next;
    logic                  w_wr_en_next;
    logic [Data_Width-1:0] w_data_next;
    logic                  w_rd_valid_next;
    logic [Data_Width-1:0] w_rd_exp_next;

    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_mismatch = r_pipe_valid[READ_LATENCY-1] &&
                        (ram_data_out != r_pipe_exp[READ_LATENCY-1]);

    // Result bookkeeping: clear on an accepted start, count/capture on mismatch.
    always_comb begin
        w_fail_count_next = r_fail_count;
        w_fail_addr_next  = r_fail_addr;
        if (w_accept) begin
            w_fail_count_next = '0;
            w_fail_addr_next  = '0;
        end else if (w_mismatch) begin
            if (r_fail_count != COUNT_MAX)
                w_fail_count_next = r_fail_count + CW'(1);
            if (r_fail_count == '0)
                w_fail_addr_next = r_pipe_addr[READ_LATENCY-1];
        end
    end

    // Phase sequencing: address counter walks each phase, drains wait out reads.
    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_drain_next = r_drain;
        w_flush      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_W0;
                    w_addr_next  = '0;
                end
            end
            ST_W0, ST_R0, ST_W1, ST_R1: begin
                if (r_addr == LAST_ADDR) begin
                    w_addr_next  = '0;
                    w_drain_next = '0;
                    case (r_state)
                        ST_W0:   w_state_next = ST_R0;
                        ST_R0:   w_state_next = ST_D0;
                        ST_W1:   w_state_next = ST_R1;
                        default: w_state_next = ST_D1;
                    endcase
                end else begin
                    w_addr_next = r_addr + AW'(1);
                end
            end
            ST_D0, ST_D1: begin
                if (r_drain == LAST_DRAIN) begin
                    w_drain_next = '0;
                    w_state_next = (r_state == ST_D0) ? ST_W1 : ST_FIN;
                end else begin
                    w_drain_next = r_drain + 3'd1;
                end
            end
            ST_FIN:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
`ifdef BIST_STOP_ON_FAIL_EN
        // First mismatch ends the run: no more accesses, drop in-flight reads.
        if (w_mismatch) begin
            w_state_next = ST_FIN;
            w_addr_next  = '0;
            w_drain_next = '0;
            w_flush      = 1'b1;
        end
`endif
    end

    // Decode the command and status for the cycle the next state occupies.
    always_comb begin
        w_busy_next     = 1'b0;
        w_done_next     = 1'b0;
        w_cs_next       = 1'b0;
        w_oe_next       = 1'b0;
        w_wr_en_next    = 1'b0;
        w_data_next     = '0;
        w_rd_valid_next = 1'b0;
        w_rd_exp_next   = '0;
        w_pass_next     = w_accept ? 1'b0 : r_pass;
        case (w_state_next)
            ST_W0, ST_W1: begin
                w_busy_next  = 1'b1;
                w_cs_next    = 1'b1;
                w_wr_en_next = 1'b1;
                w_data_next  = (w_state_next == ST_W0) ? pat_word(w_addr_next)
                                                       : ~pat_word(w_addr_next);
            end
            ST_R0, ST_R1: begin
                w_busy_next     = 1'b1;
                w_cs_next       = 1'b1;
                w_oe_next       = 1'b1;
                w_rd_valid_next = 1'b1;
                w_rd_exp_next   = (w_state_next == ST_R0) ? pat_word(w_addr_next)
                                                          : ~pat_word(w_addr_next);
            end
            ST_D0, ST_D1: w_busy_next = 1'b1;
            ST_FIN: begin
                w_done_next = 1'b1;
                w_pass_next = (w_fail_count_next == '0);
            end
            default: ;
        endcase
    end

    // Registered state, status and RAM command; reset aborts everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_drain       <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail_addr   <= '0;
            r_fail_count  <= '0;
            r_ram_cs      <= 1'b0;
            r_ram_oe      <= 1'b0;
            r_ram_wr_en   <= 1'b0;
            r_ram_data_in <= '0;
            r_rd_valid    <= 1'b0;
            r_rd_exp      <= '0;
        end else begin
            r_state       <= w_state_next;
            r_addr        <= w_addr_next;
            r_drain       <= w_drain_next;
            r_busy        <= w_busy_next;
            r_done        <= w_done_next;
            r_pass        <= w_pass_next;
            r_fail_addr   <= w_fail_addr_next;
            r_fail_count  <= w_fail_count_next;
            r_ram_cs      <= w_cs_next;
            r_ram_oe      <= w_oe_next;
            r_ram_wr_en   <= w_wr_en_next;
            r_ram_data_in <= w_data_next;
            r_rd_valid    <= w_rd_valid_next;
            r_rd_exp      <= w_rd_exp_next;
        end
    end

    // Shift issued reads down the compare pipeline so the tail meets the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_valid[i] <= 1'b0;
                r_pipe_addr[i]  <= '0;
                r_pipe_exp[i]   <= '0;
            end
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1] && !w_flush;
                r_pipe_addr[i]  <= r_pipe_addr[i-1];
                r_pipe_exp[i]   <= r_pipe_exp[i-1];
            end
            r_pipe_valid[0] <= r_rd_valid && !w_flush;
            r_pipe_addr[0]  <= r_addr;
            r_pipe_exp[0]   <= r_rd_exp;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail_addr   = r_fail_addr;
    assign fail_count  = r_fail_count;
    assign ram_cs      = r_ram_cs;
    assign ram_oe      = r_ram_oe;
    assign ram_wr_en   = r_ram_wr_en;
    assign ram_addr    = r_addr;
    assign ram_data_in = r_ram_data_in;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with defaults (8-bit, 16 words, latency 1,
// seed A5) and a one-cycle-latency RAM model with injectable faults.
module tb_ram_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_addr;
    logic [5:0] fail_count;
    logic       ram_cs;
    logic       ram_oe;
    logic       ram_wr_en;
    logic [3:0] ram_addr;
    logic [7:0] ram_data_in;
    logic [7:0] ram_data_out;

    always #5 clk = ~clk;

    ram_bist_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail_addr    (fail_addr),
        .fail_count   (fail_count),
        .ram_cs       (ram_cs),
        .ram_oe       (ram_oe),
        .ram_wr_en    (ram_wr_en),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    // Fault controls, written only by the stimulus block.
    logic       stuck_en = 1'b0;
    logic [3:0] stuck_a  = 4'd0;
    logic       corr_en  = 1'b0;
    logic [3:0] corr_a   = 4'd0;
    logic [3:0] corr_b   = 4'd0;

    // RAM model: write sets bit0 on the stuck address, reads flip all bits on
    // corrupted addresses.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (ram_cs && ram_wr_en) begin
            if (stuck_en && ram_addr == stuck_a)
                mem[ram_addr] <= ram_data_in | 8'h01;
            else
                mem[ram_addr] <= ram_data_in;
        end
        if (ram_cs && ram_oe && !ram_wr_en) begin
            if (corr_en && (ram_addr == corr_a || ram_addr == corr_b))
                ram_data_out <= mem[ram_addr] ^ 8'hFF;
            else
                ram_data_out <= mem[ram_addr];
        end
    end

    // Activity monitor: running counters and a write log.
    int         busy_cycles = 0;
    int         done_cnt    = 0;
    int         rd_cnt      = 0;
    int         wr_cnt      = 0;
    logic [3:0] wlog_addr [512];
    logic [7:0] wlog_data [512];
    always @(posedge clk) begin
        if (busy === 1'b1) busy_cycles <= busy_cycles + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (ram_cs === 1'b1 && ram_oe === 1'b1 && ram_wr_en === 1'b0) rd_cnt <= rd_cnt + 1;
        if (ram_cs === 1'b1 && ram_wr_en === 1'b1) begin
            wlog_addr[wr_cnt % 512] <= ram_addr;
            wlog_data[wr_cnt % 512] <= ram_data_in;
            wr_cnt <= wr_cnt + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One start pulse, wait for done, check result and optionally run length.
    task automatic run_and_check(input string tag, input bit chk_len, input logic exp_pass,
                                 input logic [5:0] exp_cnt, input logic [3:0] exp_addr);
        int b0;
        int d0;
        bit ok;
        b0 = busy_cycles;
        d0 = done_cnt;
        pulse_start();
        wait_done(200, ok);
        check({tag, "_done_seen"}, 32'(ok), 32'd1);
        if (chk_len) check({tag, "_busy_len"}, 32'(busy_cycles - b0), 32'd66);
        check({tag, "_pass"}, 32'(pass), 32'(exp_pass));
        check({tag, "_fail_count"}, 32'(fail_count), 32'(exp_cnt));
        check({tag, "_fail_addr"}, 32'(fail_addr), 32'(exp_addr));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int  w0;
        int  b0;
        int  d0;
        int  r0;
        int  k;
        bit  ok;

        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",   32'(busy),        32'd0);
        check("rst_done",   32'(done),        32'd0);
        check("rst_pass",   32'(pass),        32'd0);
        check("rst_fcount", 32'(fail_count),  32'd0);
        check("rst_faddr",  32'(fail_addr),   32'd0);
        check("rst_strobe", 32'({ram_cs, ram_oe, ram_wr_en}), 32'd0);
        check("rst_addr",   32'(ram_addr),    32'd0);
        check("rst_din",    32'(ram_data_in), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Clean run: first command, write pattern of addr 3, 66 busy cycles.
        w0 = wr_cnt;
        b0 = busy_cycles;
        d0 = done_cnt;
        pulse_start();
        check("first_busy", 32'(busy), 32'd1);
        check("first_cmd",  32'({ram_cs, ram_oe, ram_wr_en}), 32'b101);
        check("first_addr", 32'(ram_addr), 32'd0);
        check("first_din",  32'(ram_data_in), 32'hA5);
        wait_done(200, ok);
        check("clean_done_seen", 32'(ok), 32'd1);
        check("clean_busy_len", 32'(busy_cycles - b0), 32'd66);
        check("clean_pass", 32'(pass), 32'd1);
        check("clean_fcount", 32'(fail_count), 32'd0);
        check("w0_addr3_a", 32'(wlog_addr[(w0 + 3) % 512]), 32'd3);
        check("w0_addr3_d", 32'(wlog_data[(w0 + 3) % 512]), 32'hA6);
        check("w1_addr3_a", 32'(wlog_addr[(w0 + 19) % 512]), 32'd3);
        check("w1_addr3_d", 32'(wlog_data[(w0 + 19) % 512]), 32'h59);
        check("clean_writes", 32'(wr_cnt - w0), 32'd32);
        // start during the FIN cycle must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("fin_start_ignored", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("fin_start_idle", 32'({busy, ram_cs}), 32'd0);
        check("clean_done_once", 32'(done_cnt - d0), 32'd1);

        // Bit0 of addr 5 stuck at 1: only the R0 read mismatches.
        stuck_en = 1'b1;
        stuck_a  = 4'd5;
        run_and_check("stuck5", 1'b1, 1'b0, 6'd1, 4'd5);
        stuck_en = 1'b0;

        // Addr 2 and 9 corrupted on every read: two mismatches per read phase.
        corr_en = 1'b1;
        corr_a  = 4'd2;
        corr_b  = 4'd9;
`ifdef BIST_STOP_ON_FAIL_EN
        run_and_check("corr29", 1'b0, 1'b0, 6'd1, 4'd2);
`else
        run_and_check("corr29", 1'b1, 1'b0, 6'd4, 4'd2);
`endif
        corr_en = 1'b0;
        repeat (10) @(negedge clk);
        check("hold_pass", 32'(pass), 32'd0);
`ifdef BIST_STOP_ON_FAIL_EN
        check("hold_fcount", 32'(fail_count), 32'd1);
`else
        check("hold_fcount", 32'(fail_count), 32'd4);
`endif
        check("hold_faddr", 32'(fail_addr), 32'd2);

        // Reset during R0 at address 7: immediate abort, no done.
        pulse_start();
        k = 0;
        while (k < 100 && !(ram_oe === 1'b1 && ram_addr === 4'd7)) begin
            @(negedge clk);
            k++;
        end
        check("reach_r0_addr7", 32'(k < 100), 32'd1);
        d0 = done_cnt;
        #1 rst = 1'b1;
        #1;
        check("abort_strobes", 32'({ram_cs, ram_oe, ram_wr_en}), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_and_check("after_abort", 1'b1, 1'b1, 6'd0, 4'd0);

        // start held high for 10 cycles mid-run: exactly one run.
        b0 = busy_cycles;
        d0 = done_cnt;
        pulse_start();
        repeat (5) @(negedge clk);
        start = 1'b1;
        repeat (10) @(negedge clk);
        start = 1'b0;
        wait_done(200, ok);
        check("held_done_seen", 32'(ok), 32'd1);
        check("held_busy_len", 32'(busy_cycles - b0), 32'd66);
        repeat (80) @(negedge clk);
        check("held_done_once", 32'(done_cnt - d0), 32'd1);
        check("held_idle", 32'(busy), 32'd0);

`ifdef BIST_STOP_ON_FAIL_EN
        // Addr 4 corrupted: march stops inside R0.
        corr_en = 1'b1;
        corr_a  = 4'd4;
        corr_b  = 4'd4;
        w0 = wr_cnt;
        r0 = rd_cnt;
        d0 = done_cnt;
        pulse_start();
        k = 0;
        while (k < 100 && !(ram_oe === 1'b1 && ram_addr === 4'd4)) begin
            @(negedge clk);
            k++;
        end
        check("reach_r0_addr4", 32'(k < 100), 32'd1);
        k = 0;
        while (k < 5 && ram_cs === 1'b1) begin
            @(negedge clk);
            k++;
        end
        check("stop_cs_fall", 32'(k <= 2), 32'd1);
        repeat (5) @(negedge clk);
        corr_en = 1'b0;
        check("stop_done_once", 32'(done_cnt - d0), 32'd1);
        check("stop_fcount", 32'(fail_count), 32'd1);
        check("stop_faddr", 32'(fail_addr), 32'd4);
        check("stop_pass", 32'(pass), 32'd0);
        check("stop_no_w1", 32'(wr_cnt - w0), 32'd16);
        check("stop_no_r1", 32'((rd_cnt - r0) <= 6), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
